// File: rtl/seq_det_rr_sched.sv
// seq_det_rr_sched: round-robin time-shared 1101 overlapping Mealy detector over N_CH serial lanes
module seq_det_rr_sched #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_req,
    input  logic [N_CH-1:0]  i_din,
    input  logic [N_CH-1:0]  i_clr,
    output logic [N_CH-1:0]  o_gnt,
    output logic             o_y,
    output logic [CH_W-1:0]  o_y_ch,
    output logic [CNT_W-1:0] o_match_cnt
);
    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
    state_t          r_st [N_CH];
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_g;
    logic [N_CH-1:0] w_elig;
    logic            w_any;
    logic            w_d;
    logic            w_match;
    state_t          w_cur;
    state_t          w_nxt;
    assign w_elig = i_req & ~i_clr;
    always_comb begin
        w_any = 1'b0;
        w_g   = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (w_elig[i] && CH_W'(i) < r_ptr) begin
                w_any = 1'b1;
                w_g   = CH_W'(i);
            end
        for (int i = N_CH - 1; i >= 0; i--)
            if (w_elig[i] && CH_W'(i) >= r_ptr) begin
                w_any = 1'b1;
                w_g   = CH_W'(i);
            end
    end
    assign o_gnt   = w_any ? (N_CH'(1) << w_g) : '0;
    assign w_cur   = r_st[w_g];
    assign w_d     = i_din[w_g];
    assign w_nxt   = w_d ? ((w_cur == S0 || w_cur == S3) ? S1 : S2) : ((w_cur == S2) ? S3 : S0);
    assign w_match = w_any && w_d && (w_cur == S3);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_CH; i++) r_st[i] <= S0;
            r_ptr       <= '0;
            o_y         <= 1'b0;
            o_y_ch      <= '0;
            o_match_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) if (i_clr[i]) r_st[i] <= S0;
            if (w_any) begin
                r_st[w_g] <= w_nxt;
                r_ptr     <= (w_g == CH_W'(N_CH - 1)) ? '0 : w_g + CH_W'(1);
            end
            o_y <= w_match;
            if (w_match) begin
                o_y_ch      <= w_g;
                o_match_cnt <= o_match_cnt + CNT_W'(o_match_cnt != '1);
            end
        end
    end
endmodule

// File: tb/tb_seq_det_rr_sched.sv
// tb_seq_det_rr_sched: scoreboard bench against a bit-history reference model
module tb_seq_det_rr_sched;
    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;
    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [N_CH-1:0]  i_req = '0;
    logic [N_CH-1:0]  i_din = '0;
    logic [N_CH-1:0]  i_clr = '0;
    logic [N_CH-1:0]  o_gnt;
    logic             o_y;
    logic [CH_W-1:0]  o_y_ch;
    logic [CNT_W-1:0] o_match_cnt;
    seq_det_rr_sched #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_din(i_din), .i_clr(i_clr),
        .o_gnt(o_gnt), .o_y(o_y), .o_y_ch(o_y_ch), .o_match_cnt(o_match_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {int cyc; int ch; int cnt;} exp_t;
    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit armed   = 0;
    logic [3:0] m_hist [N_CH];
    int m_ptr = 0, m_cnt = 0, m_ych = 0;
    logic [N_CH-1:0] last_gnt = '0;
    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask
    // Matching is a pure suffix test on the bits each channel has had accepted since its last clear/reset.
    task automatic drive(input logic rst, input logic [N_CH-1:0] req, input logic [N_CH-1:0] din,
                         input logic [N_CH-1:0] clr);
        logic [N_CH-1:0] eg, eg_gnt;
        int g;
        if (armed) begin
            check("match_cnt", int'(o_match_cnt), m_cnt);
            check("y_ch_hold", int'(o_y_ch), m_ych);
        end
        i_rst = rst; i_req = req; i_din = din; i_clr = clr;
        #1;
        eg = req & ~clr;
        g  = -1;
        for (int k = 0; k < N_CH; k++)
            if (g < 0 && eg[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
        eg_gnt = (g < 0) ? '0 : N_CH'(1) << g;
        check("gnt", int'(o_gnt), int'(eg_gnt));
        last_gnt = eg_gnt;
        if (rst) begin
            for (int i = 0; i < N_CH; i++) m_hist[i] = '0;
            m_ptr = 0; m_cnt = 0; m_ych = 0;
        end else begin
            for (int i = 0; i < N_CH; i++) if (clr[i]) m_hist[i] = '0;
            if (g >= 0) begin
                m_hist[g] = {m_hist[g][2:0], din[g]};
                m_ptr = (g + 1) % N_CH;
                if (m_hist[g] == 4'b1101) begin
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                    m_ych = g;
                    q.push_back('{cyc + 1, g, m_cnt});
                end
            end
        end
        armed = 1;
    endtask
    task automatic step(input logic rst, input logic [N_CH-1:0] req, input logic [N_CH-1:0] din,
                        input logic [N_CH-1:0] clr);
        @(negedge clk);
        drive(rst, req, din, clr);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (o_y) begin
                if (q.size() == 0) check("unexpected_y", 1, 0);
                else begin
                    e = q.pop_front();
                    check("y_cycle", cyc, e.cyc);
                    check("y_ch", int'(o_y_ch), e.ch);
                    check("y_cnt", int'(o_match_cnt), e.cnt);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check("missing_y", 0, 1);
            end
        end
    end
    initial begin
        logic [3:0] pat;
        logic [N_CH-1:0] rq, dn, cl;
        pat = 4'b1101;
        step(1, '0, '0, '0);
        step(1, 4'b0101, '0, 4'b0100);
        @(negedge clk);
        check("reset_y", int'(o_y), 0);
        check("reset_cnt", int'(o_match_cnt), 0);
        foreach (pat[b]) step(0, 4'b0001, {3'b0, pat[b]}, '0);
        step(0, '0, '0, '0);
        for (int b = 3; b >= 1; b--) step(0, 4'b0001, {3'b0, pat[b]}, '0);
        step(0, '0, '0, '0);
        step(1, '0, '0, '0);
        for (int c = 0; c < 16; c++) step(0, 4'b1111, {4{pat[3 - c / 4]}}, '0);
        for (int b = 3; b >= 1; b--) step(0, 4'b0100, {1'b0, pat[b], 2'b0}, '0);
        step(0, 4'b0100, 4'b0100, 4'b0100);
        step(0, 4'b0100, 4'b0100, '0);
        for (int b = 3; b >= 1; b--) step(0, 4'b1000, {pat[b], 3'b0}, '0);
        step(1, '0, '0, '0);
        step(0, 4'b1000, 4'b1000, '0);
        step(0, '0, '0, '0);
        for (int b = 3; b >= 0; b--) begin
            step(0, 4'b1010, {pat[b], 1'b0, pat[b], 1'b0}, '0);
            step(0, 4'b1010, {pat[b], 1'b0, pat[b], 1'b0}, '0);
        end
        rq = '0; dn = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_CH; i++)
                if (!(rq[i] && !last_gnt[i] && !cl[i])) begin
                    rq[i] = ($urandom_range(0, 3) != 0);
                    dn[i] = ($urandom_range(0, 3) != 0);
                end
            for (int i = 0; i < N_CH; i++) cl[i] = ($urandom_range(0, 24) == 0);
            step(($urandom_range(0, 299) == 0), rq, dn, cl);
        end
        step(0, '0, '0, '0);
        step(0, '0, '0, '0);
        step(0, '0, '0, '0);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
